r2b_converter_pp: RTL and testbench

- Streaming row-to-block converter with ping-pong slice buffering and valid/ready handshakes on both sides.
- Accepts a ROW x COL matrix one row per beat. Emits BLOCK_SIZE x BLOCK_SIZE blocks stacked vertically for NUM_CORES matrix-multiply cores, one column-chunk per beat.
- Filling one slice overlaps with draining the other, so the full-matrix RAM is not needed.
- Sits between the input row source and the vertical core array of the self-attention head.

---
 rtl/r2b_converter_pp.sv | 182 ++++++++++++++++++
 tb/tb_r2b_converter_pp.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/r2b_converter_pp.sv
// rtl/r2b_converter_pp.sv - row-to-block converter with ping-pong slice banks.
// Optional stall_cycles output under R2B_STALL_CNT_EN.
module r2b_converter_pp #(
   parameter int WIDTH      = 16,
   parameter int BLOCK_SIZE = 2,
   parameter int NUM_CORES  = 2,
   parameter int ROW        = 64,
   parameter int COL        = 16
) (
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic                                          en,
   input  logic                                          in_valid,
   output logic                                          in_ready,
   input  logic [WIDTH*COL-1:0]                          in_data,
   output logic                                          out_valid,
   input  logic                                          out_ready,
   output logic [WIDTH*BLOCK_SIZE*BLOCK_SIZE*NUM_CORES-1:0] out_data,
   output logic                                          out_first,
   output logic                                          out_slice_last,
   output logic                                          out_last,
   output logic                                          busy,
   output logic                                          done
`ifdef R2B_STALL_CNT_EN
   ,
   output logic [31:0]                                   stall_cycles
`endif
);

   localparam int SLICE_ROWS = BLOCK_SIZE * NUM_CORES;
   localparam int CHUNKS     = COL / BLOCK_SIZE;
   localparam int SLICES     = ROW / SLICE_ROWS;
   localparam int ELEMS      = BLOCK_SIZE * BLOCK_SIZE * NUM_CORES;
   localparam int RW         = WIDTH * COL;
   localparam int OW         = WIDTH * ELEMS;
   localparam int RIW        = $clog2(ROW + 1);
   localparam int WRW        = (SLICE_ROWS > 1) ? $clog2(SLICE_ROWS) : 1;
   localparam int CW         = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam int SW         = (SLICES > 1) ? $clog2(SLICES) : 1;

   localparam logic [RIW-1:0] ROW_L      = RIW'(ROW);
   localparam logic [WRW-1:0] LAST_WROW  = WRW'(SLICE_ROWS - 1);
   localparam logic [CW-1:0]  LAST_CHUNK = CW'(CHUNKS - 1);
   localparam logic [SW-1:0]  LAST_SLICE = SW'(SLICES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state, state_nxt;
   logic [RW-1:0]  bank [2][SLICE_ROWS];
   logic [1:0]     full, full_nxt;
   logic           wr_bank, rd_bank, ld_bank;
   logic [WRW-1:0] wr_row;
   logic [RIW-1:0] rows_in;
   logic [CW-1:0]  cur_chunk, ld_chunk;
   logic [SW-1:0]  rd_slice;
   logic [OW-1:0]  ld_data;
   logic           accept, hs, slice_done, load;

   assign in_ready       = (state == RUN) && !full[wr_bank] && (rows_in < ROW_L);
   assign accept         = in_valid && in_ready;
   assign hs             = out_valid && out_ready;
   assign slice_done     = hs && (cur_chunk == LAST_CHUNK);
   assign out_first      = out_valid && (cur_chunk == '0);
   assign out_slice_last = out_valid && (cur_chunk == LAST_CHUNK);
   assign out_last       = out_valid && (cur_chunk == LAST_CHUNK) && (rd_slice == LAST_SLICE);
   assign busy           = (state != IDLE);
   assign done           = (state == DONE);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (en) state_nxt = RUN;
         RUN:     if (hs && out_last) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Set and clear in the same cycle always hit opposite banks.
   always_comb begin
      full_nxt = full;
      if (slice_done) full_nxt[rd_bank] = 1'b0;
      if (accept && (wr_row == LAST_WROW)) full_nxt[wr_bank] = 1'b1;
      if (state == DONE) full_nxt = '0;
   end

   // Finishing a slice pulls chunk 0 of the other bank straight in when it is ready.
   always_comb begin
      load     = 1'b0;
      ld_bank  = rd_bank;
      ld_chunk = '0;
      if (state == RUN) begin
         if (slice_done) begin
            ld_bank = ~rd_bank;
            load    = full[~rd_bank];
         end else if (hs) begin
            load     = 1'b1;
            ld_chunk = cur_chunk + CW'(1);
         end else if (!out_valid) begin
            load = full[rd_bank];
         end
      end
   end

   always_comb begin
      int col;
      col     = 0;
      ld_data = '0;
      for (int k = 0; k < NUM_CORES; k++) begin
         for (int i = 0; i < BLOCK_SIZE; i++) begin
            for (int j = 0; j < BLOCK_SIZE; j++) begin
               col = int'(ld_chunk) * BLOCK_SIZE + j;
               ld_data[(ELEMS-1-(k*BLOCK_SIZE*BLOCK_SIZE + i*BLOCK_SIZE + j))*WIDTH +: WIDTH] =
                  bank[ld_bank][k*BLOCK_SIZE + i][(COL-1-col)*WIDTH +: WIDTH];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) bank[wr_bank][wr_row] <= in_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         full      <= '0;
         wr_bank   <= 1'b0;
         rd_bank   <= 1'b0;
         wr_row    <= '0;
         rows_in   <= '0;
         cur_chunk <= '0;
         rd_slice  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         state <= state_nxt;
         full  <= full_nxt;
         if (accept) begin
            rows_in <= rows_in + RIW'(1);
            if (wr_row == LAST_WROW) begin
               wr_row  <= '0;
               wr_bank <= ~wr_bank;
            end else begin
               wr_row <= wr_row + WRW'(1);
            end
         end
         if (slice_done) begin
            rd_bank  <= ~rd_bank;
            rd_slice <= (rd_slice == LAST_SLICE) ? '0 : rd_slice + SW'(1);
         end
         if (!out_valid || out_ready) begin
            out_valid <= load;
            if (load) begin
               out_data  <= ld_data;
               cur_chunk <= ld_chunk;
            end
         end
         if (state == DONE) begin
            rows_in   <= '0;
            wr_row    <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            cur_chunk <= '0;
            rd_slice  <= '0;
         end
      end
   end

`ifdef R2B_STALL_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
      end else if ((state == IDLE) && en) begin
         stall_cycles <= '0;
      end else if ((state == RUN) && out_valid && !out_ready && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_r2b_converter_pp.sv
// tb/tb_r2b_converter_pp.sv - scoreboard bench for r2b_converter_pp (8x8, 2x2 blocks, 2 cores).
module tb_r2b_converter_pp;

   localparam int W  = 16;
   localparam int BS = 2;
   localparam int NC = 2;
   localparam int R  = 8;
   localparam int C  = 8;
   localparam int RW = W * C;
   localparam int OW = W * BS * BS * NC;

   logic          clk = 1'b0;
   logic          rst_n, en, in_valid, in_ready, out_valid, out_ready;
   logic [RW-1:0] in_data;
   logic [OW-1:0] out_data;
   logic          out_first, out_slice_last, out_last, busy, done;
`ifdef R2B_STALL_CNT_EN
   logic [31:0]   stall_cycles;
`endif

   r2b_converter_pp #(.WIDTH(W), .BLOCK_SIZE(BS), .NUM_CORES(NC), .ROW(R), .COL(C)) dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_first(out_first), .out_slice_last(out_slice_last), .out_last(out_last),
      .busy(busy), .done(done)
`ifdef R2B_STALL_CNT_EN
      , .stall_cycles(stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [OW-1:0] d;
      logic          f;
      logic          sl;
      logic          l;
   } exp_t;

   exp_t          sbq[$];
   int            hs_cyc[$];
   logic [OW-1:0] hs_dat[$];
   int            vectors = 0, miscompares = 0;
   int            cyc = 0, hs_cnt = 0, done_cnt = 0, rows_acc = 0;
   int            first_valid = -1, slice0_acc = -1;
   logic          stalled = 1'b0;
   logic [131:0]  held;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [131:0] obs, input logic [131:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [RW-1:0] mk_row(input int base, input int r);
      logic [RW-1:0] v;
      v = '0;
      for (int c = 0; c < C; c++) v[(C-1-c)*W +: W] = W'(base + r*C + c);
      return v;
   endfunction

   function automatic logic [OW-1:0] exp_chunk(input int base, input int s, input int c);
      logic [OW-1:0] v;
      v = '0;
      for (int k = 0; k < NC; k++)
         for (int i = 0; i < BS; i++)
            for (int j = 0; j < BS; j++)
               v[(7-(k*4 + i*2 + j))*W +: W] = W'(base + (s*4 + k*2 + i)*C + c*2 + j);
      return v;
   endfunction

   function automatic logic [OW-1:0] pack8(input int a, input int b, input int c, input int d,
                                           input int e, input int f, input int g, input int h);
      return {W'(a), W'(b), W'(c), W'(d), W'(e), W'(f), W'(g), W'(h)};
   endfunction

   // Output monitor: pops the scoreboard on each handshake, checks hold under stall.
   always @(negedge clk) begin
      if (!rst_n) begin
         stalled = 1'b0;
      end else begin
         if (done) done_cnt++;
         if (out_valid && first_valid < 0) first_valid = cyc;
         if (out_valid && !out_ready) begin
            if (stalled) chk("hold", {out_first, out_slice_last, out_last, 1'b0, out_data}, held);
            stalled = 1'b1;
            held    = {out_first, out_slice_last, out_last, 1'b0, out_data};
         end else begin
            stalled = 1'b0;
         end
         if (out_valid && out_ready) begin
            exp_t e;
            hs_cnt++;
            hs_cyc.push_back(cyc);
            hs_dat.push_back(out_data);
            if (sbq.size() == 0) begin
               chk("sb_empty", 132'(0), 132'(1));
            end else begin
               e = sbq.pop_front();
               chk("chunk", {out_first, out_slice_last, out_last, 1'b0, out_data},
                   {e.f, e.sl, e.l, 1'b0, e.d});
            end
         end
      end
   end

   task automatic start_matrix();
      hs_cnt = 0;
      rows_acc = 0;
      first_valid = -1;
      hs_cyc.delete();
      hs_dat.delete();
      en = 1'b1;
      @(negedge clk);
      en = 1'b0;
   endtask

   task automatic send_matrix(input int base, input int nrows);
      for (int r = 0; r < nrows; r++) begin
         int t = 0;
         in_valid = 1'b1;
         in_data  = mk_row(base, r);
         while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
         end
         if (!in_ready) begin
            chk("in_ready_tmo", 132'(0), 132'(1));
            break;
         end
         @(posedge clk);
         rows_acc++;
         if (r % 4 == 3) begin
            for (int c = 0; c < 4; c++) begin
               exp_t e;
               e.d  = exp_chunk(base, r/4, c);
               e.f  = (c == 0);
               e.sl = (c == 3);
               e.l  = (c == 3) && (r/4 == R/4 - 1);
               sbq.push_back(e);
            end
         end
         @(negedge clk);
         if (r == 3) slice0_acc = cyc;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input int n);
      int t = 0;
      while (done_cnt < n && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk("done_wait", 132'(done_cnt), 132'(n));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_flags", 132'({out_valid, in_ready, busy, done, out_first, out_slice_last, out_last}), 132'(0));
      chk("rst_data", 132'(out_data), 132'(0));
      rst_n = 1'b1;
      @(negedge clk);

      // Back-to-back rows, no backpressure.
      start_matrix();
      chk("busy_run", 132'(busy), 132'(1));
      send_matrix(0, 8);
      wait_done(1);
      repeat (3) @(negedge clk);
      chk("done_once", 132'(done_cnt), 132'(1));
      chk("idle_busy", 132'(busy), 132'(0));
      chk("hs_cnt", 132'(hs_cnt), 132'(8));
      chk("chunk0", 132'(hs_dat[0]), 132'(pack8(0, 1, 8, 9, 16, 17, 24, 25)));
      chk("chunk7", 132'(hs_dat[7]), 132'(pack8(38, 39, 46, 47, 54, 55, 62, 63)));
      chk("latency", 132'(first_valid), 132'(slice0_acc + 1));
      chk("no_bubble", 132'(hs_cyc[4] - hs_cyc[3]), 132'(1));
      chk("sb_left", 132'(sbq.size()), 132'(0));

      // Ten cycles of backpressure mid-slice.
      start_matrix();
      fork
         send_matrix(100, 8);
         begin
            int t = 0;
            while (hs_cnt < 2 && t < 300) begin
               @(negedge clk);
               t++;
            end
            chk("bp_start", 132'(hs_cnt >= 2), 132'(1));
            @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (10) @(posedge clk);
            #1;
            chk("bp_in_ready", 132'(in_ready), 132'(0));
            chk("bp_rows", 132'(rows_acc), 132'(8));
            out_ready = 1'b1;
         end
      join
      wait_done(2);
      chk("bp_hs_cnt", 132'(hs_cnt), 132'(8));
      chk("bp_sb_left", 132'(sbq.size()), 132'(0));
`ifdef R2B_STALL_CNT_EN
      chk("stall_at_done", 132'(stall_cycles), 132'(10));
      repeat (3) @(negedge clk);
      chk("stall_hold", 132'(stall_cycles), 132'(10));
`endif

      // Reset during slice 1, then a fresh matrix.
      start_matrix();
`ifdef R2B_STALL_CNT_EN
      chk("stall_clear", 132'(stall_cycles), 132'(0));
`endif
      send_matrix(200, 6);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_flags", 132'({out_valid, in_ready, busy, done, out_first, out_slice_last, out_last}), 132'(0));
      chk("mid_rst_data", 132'(out_data), 132'(0));
      sbq.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start_matrix();
      send_matrix(300, 8);
      wait_done(3);
      chk("re_hs_cnt", 132'(hs_cnt), 132'(8));
      chk("re_chunk0", 132'(hs_dat[0]), 132'(pack8(300, 301, 308, 309, 316, 317, 324, 325)));
      chk("re_sb_left", 132'(sbq.size()), 132'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
